// File: rtl/jtag_dbg_bridge.sv
// JTAG DR to bus bridge: a 2+A+D bit scan chain issues single read/write bus transactions.
// Latency: request one cycle after Update-DR; response accepted no earlier than the cycle after grant.
// Backpressure: req_o held until gnt_i; rvalid_i awaited up to TIMEOUT_CYCLES, updates ignored while busy.
module jtag_dbg_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sel_i,
    input  logic                    capture_dr_i,
    input  logic                    shift_dr_i,
    input  logic                    update_dr_i,
    input  logic                    scan_in_i,
    output logic                    scan_out_o,
    output logic                    req_o,
    input  logic                    gnt_i,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] be_o,
    input  logic                    rvalid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    err_i,
    output logic                    busy_o
);

    localparam int W = 2 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                  state_q;
    logic [W-1:0]            dr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    we_q;
    logic [1:0]              status_q;
    logic [7:0]              cnt_q;
    logic                    req_q;
    logic                    busy_q;

    logic [1:0]              dr_op;
    logic [ADDR_WIDTH-1:0]   dr_addr;
    logic [DATA_WIDTH-1:0]   dr_data;
    logic [1:0]              cap_status;

    assign dr_op   = dr_q[W-1 -: 2];
    assign dr_addr = dr_q[W-3 -: ADDR_WIDTH];
    assign dr_data = dr_q[DATA_WIDTH-1:0];

    // A capture while a transaction is in flight reports busy, not the stale result.
    assign cap_status = (state_q != IDLE) ? 2'b01 : status_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dr_q <= '0;
        end else if (sel_i && capture_dr_i) begin
            dr_q <= {cap_status, addr_q, rdata_q};
        end else if (sel_i && shift_dr_i) begin
            dr_q <= {scan_in_i, dr_q[W-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rdata_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            status_q <= 2'b00;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_i && update_dr_i && (dr_op == OP_READ || dr_op == OP_WRITE)) begin
                        addr_q   <= dr_addr;
                        wdata_q  <= dr_data;
                        we_q     <= (dr_op == OP_WRITE);
                        status_q <= 2'b00;
                        state_q  <= REQ;
                        req_q    <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (gnt_i) begin
                        state_q <= RESP;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RESP: begin
                    if (rvalid_i) begin
                        if (!we_q) begin
                            rdata_q <= rdata_i;
                        end
                        status_q <= err_i ? 2'b10 : 2'b00;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end else if (cnt_q + 8'd1 == TIMEOUT_LAST) begin
                        status_q <= 2'b11;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign scan_out_o = dr_q[0];
    assign req_o      = req_q;
    assign busy_o     = busy_q;
    assign we_o       = we_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign be_o       = {(DATA_WIDTH/8){req_q}};

endmodule
